// File: rtl/jt5205_enc.sv
// OKI/MSM5205 ADPCM encoder: 12-bit signed PCM in, 4-bit nibble out.
// Quantiser, step table and predictor update match the decoder core bit for bit.
`timescale 1ns/1ps
module jt5205_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        clr,
  input  logic [11:0] pcm,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  output logic [3:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [11:0] pred
);

  typedef enum logic [2:0] {IDLE, SUB, Q2, Q1, Q0, UPD} state_t;

  state_t             state_reg, state_next;
  logic signed [11:0] pcm_reg, pcm_next;
  logic signed [11:0] pred_reg, pred_next;
  logic [5:0]         idx_reg, idx_next;
  logic               sign_reg, sign_next;
  logic [12:0]        mag_reg, mag_next;
  logic [2:0]         bits_reg, bits_next;
  logic [3:0]         dout_reg, dout_next;
  logic               dout_valid_reg, dout_valid_next;

  function automatic logic [10:0] step_lut(input logic [5:0] i);
    case (i)
      6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
      6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
      6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
      6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  logic [12:0]        step_w;
  logic signed [12:0] d;
  logic [12:0]        mag_abs;
  logic [12:0]        diff;
  logic signed [13:0] pred_ext, diff_ext, pred_sum;
  logic signed [7:0]  adj, idx_sum;

  assign step_w  = {2'b00, step_lut(idx_reg)};
  // 13-bit difference cannot wrap for any 12-bit pcm/predictor pair
  assign d       = {pcm_reg[11], pcm_reg} - {pred_reg[11], pred_reg};
  assign mag_abs = d[12] ? 13'(-d) : 13'(d);
  assign diff    = (step_w >> 3)
                 + (bits_reg[0] ? (step_w >> 2) : 13'd0)
                 + (bits_reg[1] ? (step_w >> 1) : 13'd0)
                 + (bits_reg[2] ? step_w        : 13'd0);
  assign pred_ext = {{2{pred_reg[11]}}, pred_reg};
  assign diff_ext = {1'b0, diff};
  assign pred_sum = sign_reg ? (pred_ext - diff_ext) : (pred_ext + diff_ext);

  always_comb begin
    case (bits_reg)
      3'd4:    adj = 8'sd2;
      3'd5:    adj = 8'sd4;
      3'd6:    adj = 8'sd6;
      3'd7:    adj = 8'sd8;
      default: adj = -8'sd1;
    endcase
  end

  assign idx_sum   = $signed({2'b00, idx_reg}) + adj;
  assign pcm_ready = (state_reg == IDLE) && !dout_valid_reg;

  always_comb begin
    state_next      = state_reg;
    pcm_next        = pcm_reg;
    pred_next       = pred_reg;
    idx_next        = idx_reg;
    sign_next       = sign_reg;
    mag_next        = mag_reg;
    bits_next       = bits_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    case (state_reg)
      IDLE: begin
        if (dout_valid_reg && dout_ready) dout_valid_next = 1'b0;
        if (pcm_valid && pcm_ready) begin
          pcm_next   = pcm;
          state_next = SUB;
        end
      end
      SUB: begin
        sign_next  = d[12];
        mag_next   = mag_abs;
        bits_next  = 3'b000;
        state_next = Q2;
      end
      Q2: begin
        if (mag_reg >= step_w) begin
          bits_next[2] = 1'b1;
          mag_next     = mag_reg - step_w;
        end
        state_next = Q1;
      end
      Q1: begin
        if (mag_reg >= (step_w >> 1)) begin
          bits_next[1] = 1'b1;
          mag_next     = mag_reg - (step_w >> 1);
        end
        state_next = Q0;
      end
      Q0: begin
        if (mag_reg >= (step_w >> 2)) bits_next[0] = 1'b1;
        state_next = UPD;
      end
      UPD: begin
        if (pred_sum > 14'sd2047)        pred_next = 12'sd2047;
        else if (pred_sum < -14'sd2048)  pred_next = -12'sd2048;
        else                             pred_next = pred_sum[11:0];
        if (idx_sum < 8'sd0)             idx_next = 6'd0;
        else if (idx_sum > 8'sd48)       idx_next = 6'd48;
        else                             idx_next = idx_sum[5:0];
        dout_next       = {sign_reg, bits_reg};
        dout_valid_next = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // clr overrides cen so a restart is never lost behind a stalled enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pcm_reg        <= '0;
      pred_reg       <= '0;
      idx_reg        <= '0;
      sign_reg       <= 1'b0;
      mag_reg        <= '0;
      bits_reg       <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else if (clr) begin
      state_reg      <= IDLE;
      pcm_reg        <= '0;
      pred_reg       <= '0;
      idx_reg        <= '0;
      sign_reg       <= 1'b0;
      mag_reg        <= '0;
      bits_reg       <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else if (cen) begin
      state_reg      <= state_next;
      pcm_reg        <= pcm_next;
      pred_reg       <= pred_next;
      idx_reg        <= idx_next;
      sign_reg       <= sign_next;
      mag_reg        <= mag_next;
      bits_reg       <= bits_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign pred       = pred_reg;

endmodule

// File: tb/tb_jt5205_enc.sv
// Scoreboard bench for jt5205_enc: directed samples with hand-worked nibbles
// and predictor values, checked by a monitor on every consumed nibble.
`timescale 1ns/1ps
module tb_jt5205_enc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        clr = 1'b0;
  logic [11:0] pcm = '0;
  logic        pcm_valid = 1'b0;
  logic        pcm_ready;
  logic [3:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [11:0] pred;

  int          errors = 0;
  int          checks = 0;
  int          n_out = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  bit          rand_mode = 1'b0;
  logic        force_cen = 1'b1;
  logic        force_rdy = 1'b1;

  // Samples in stream order from reset; expected nibble and predictor worked by hand
  int vp[16] = '{0, 100, 100, 100, -100, 0, 50, 0, 200, 300, 2047, 2047, 2047, -2048, -2048, -2048};
  int vd[16] = '{'h0, 'h7, 'h7, 'h0, 'hF, 'h0, 'h1, 'h9, 'h7, 'h1, 'h7, 'h7, 'h2, 'hF, 'hE, 'h0};
  int vr[16] = '{2, 32, 95, 104, -19, -2, 46, 3, 202, 287, 678, 1519, 2047, 405, -2048, -1854};

  jt5205_enc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .clr        (clr),
    .pcm        (pcm),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .pred       (pred)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // cen / dout_ready driver: random in rand_mode, otherwise forced levels
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        cen        = ($urandom_range(3) == 0);
        dout_ready = ($urandom_range(2) != 0);
      end else begin
        cen        = force_cen;
        dout_ready = force_rdy;
      end
    end
  end

  // Monitor: a nibble transfer happens on the next rising edge
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready && cen && !clr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected nibble: got dout=0x%0h pred=0x%0h, want none", dout, pred);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("nibble%0d dout", n_out), 16'(dout), 16'(e[15:12]));
        check($sformatf("nibble%0d pred", n_out), 16'(pred), 16'(e[11:0]));
        n_out++;
      end
    end
  end

  task automatic send(input int s, input int ed, input int ep, input bit push);
    int n = 0;
    bit done = 1'b0;
    pcm = 12'(s);
    pcm_valid = 1'b1;
    while (!done && n < 3000) begin
      @(negedge clk);
      done = pcm_ready && cen && !clr;
      @(posedge clk);
      #1;
      n++;
    end
    pcm_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept timeout pcm=%0d: got no accept, want accept", s);
    end else if (push) begin
      exp_q.push_back({4'(ed), 12'(ep)});
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 16'(exp_q.size()), 16'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset dout_valid", 16'(dout_valid), 16'd0);
    check("reset pcm_ready", 16'(pcm_ready), 16'd1);
    check("reset pred", 16'(pred), 16'd0);
    check("reset dout", 16'(dout), 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First sample: exact five-edge latency with predictor update on the same edge
    send(vp[0], vd[0], vr[0], 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("latency k+4 dout_valid", 16'(dout_valid), 16'd0);
    check("latency k+4 pred", 16'(pred), 16'd0);
    @(posedge clk);
    #1;
    check("latency k+5 dout_valid", 16'(dout_valid), 16'd1);
    check("latency k+5 pred", 16'(pred), 16'd2);

    for (int i = 1; i < 8; i++) send(vp[i], vd[i], vr[i], 1'b1);

    // Remaining stream under random cen duty and consumer gaps, incl. both clamps
    rand_mode = 1'b1;
    for (int i = 8; i < 16; i++) send(vp[i], vd[i], vr[i], 1'b1);
    drain("random phase drain");
    rand_mode = 1'b0;
    @(posedge clk);
    #1;

    // Back-pressure: nibble held, no new accept, nothing overwritten
    pulse_clr();
    check("clr pred", 16'(pred), 16'd0);
    check("clr pcm_ready", 16'(pcm_ready), 16'd1);
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    send(-2048, 'hF, -30, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("stall dout_valid", 16'(dout_valid), 16'd1);
    check("stall pcm_ready", 16'(pcm_ready), 16'd0);
    check("stall dout", 16'(dout), 16'hF);
    force_rdy = 1'b1;
    drain("stall drain");

    // clr while the sample is in Q1: sample dropped, fresh state after
    send(500, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("abort dout_valid", 16'(dout_valid), 16'd0);
    check("abort pred", 16'(pred), 16'd0);
    check("abort pcm_ready", 16'(pcm_ready), 16'd1);
    repeat (10) @(posedge clk);
    #1;
    check("abort no output", 16'(dout_valid), 16'd0);
    send(100, 'h7, 30, 1'b1);
    drain("post-clr drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
